// File: rtl/mul_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM state encoding and counter sizing.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package mul_pkg;

    // Controller states; the encoding is visible to the ALU, so it is fixed explicitly.
    typedef enum logic [1:0] {
        CLEAR  = 2'b00,
        FINISH = 2'b01,
        START  = 2'b10,
        DOING  = 2'b11
    } state_t;

    // Bits needed for a step counter that is loaded with WIDTH and counts down through 0.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/subtract/skip the multiplicand, then arithmetic shift right by one.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module booth_step #(
    parameter int EW = 33                      // extended operand width (WIDTH + 1)
) (
    input  logic [2*EW:0]  acc_i,              // {upper partial sum (EW+1 bits), multiplier part (EW bits)}
    input  logic           guard_i,            // Booth guard bit (previous multiplier LSB)
    input  logic [EW-1:0]  mcand_i,            // extended multiplicand
    output logic [2*EW:0]  acc_o,
    output logic           guard_o
);

    localparam int AW = EW + 1;                // upper half is one bit wider so A +/- M never wraps

    logic [AW-1:0] hi;
    logic [AW-1:0] mext;
    logic [AW-1:0] sum;

    // Select the Booth action from {Q0, guard}, then shift {sum, Q, guard} right arithmetically.
    always_comb begin
        hi   = acc_i[2*EW:EW];
        mext = {mcand_i[EW-1], mcand_i};
        case ({acc_i[0], guard_i})
            2'b01:   sum = hi + mext;
            2'b10:   sum = hi - mext;
            default: sum = hi;
        endcase
        acc_o   = {sum[AW-1], sum, acc_i[EW-1:1]};
        guard_o = acc_i[0];
    end

endmodule

// File: rtl/seq_booth_multiplier.sv
// Sequential radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per operation.
// Latency: op_done and result appear WIDTH+2 cycles after the op_start sampling edge.
// Backpressure: result held in FINISH until op_clear; op_start is only accepted in CLEAR.
// Optional: define MUL_OVERFLOW_EN to add the result_ovf output.
module seq_booth_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 op_start,
    input  logic                 op_clear,
    input  logic                 op_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   result,
    output logic                 op_done,
    output logic                 busy
`ifdef MUL_OVERFLOW_EN
    ,
    output logic                 result_ovf
`endif
);

    localparam int EW   = WIDTH + 1;           // operands carry one extra bit so both modes are exact
    localparam int ACCW = 2 * EW + 1;
    localparam int CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

    // Sign- or zero-extend an operand to EW bits.
    function automatic logic [EW-1:0] extend(input logic [WIDTH-1:0] v, input logic s);
        return {s & v[WIDTH-1], v};
    endfunction

    state_t              state_q;
    logic [EW-1:0]       mcand_q;
    logic [EW-1:0]       mplier_q;
    logic [ACCW-1:0]     acc_q;
    logic [ACCW-1:0]     acc_d;
    logic                guard_q;
    logic                guard_d;
    logic [CW-1:0]       cnt_q;
    logic [2*WIDTH-1:0]  result_q;
    logic [2*WIDTH-1:0]  result_d;
`ifdef MUL_OVERFLOW_EN
    logic                signed_q;
    logic                ovf_q;
    logic                ovf_d;
`endif

    booth_step #(
        .EW (EW)
    ) u_booth_step (
        .acc_i   (acc_q),
        .guard_i (guard_q),
        .mcand_i (mcand_q),
        .acc_o   (acc_d),
        .guard_o (guard_d)
    );

    // Product after the step in flight; only the low 2*WIDTH bits are meaningful.
    assign result_d = acc_d[2*WIDTH-1:0];

`ifdef MUL_OVERFLOW_EN
    // Product does not fit in WIDTH bits: unsigned needs a zero upper half, signed a uniform sign run.
    always_comb begin
        if (signed_q) begin
            ovf_d = !((&result_d[2*WIDTH-1:WIDTH-1]) || !(|result_d[2*WIDTH-1:WIDTH-1]));
        end else begin
            ovf_d = |result_d[2*WIDTH-1:WIDTH];
        end
    end
`endif

    // Controller plus datapath registers; op_clear wins in every state and wipes all state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= CLEAR;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            guard_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
`ifdef MUL_OVERFLOW_EN
            signed_q <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else if (op_clear || (state_q == CLEAR && !op_start)) begin
            state_q  <= CLEAR;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            guard_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
`ifdef MUL_OVERFLOW_EN
            signed_q <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                CLEAR: begin
                    state_q  <= START;
                    mcand_q  <= extend(multiplicand, op_signed);
                    mplier_q <= extend(multiplier, op_signed);
`ifdef MUL_OVERFLOW_EN
                    signed_q <= op_signed;
`endif
                end
                START: begin
                    state_q <= DOING;
                    acc_q   <= {{(EW + 1){1'b0}}, mplier_q};
                    guard_q <= 1'b0;
                    cnt_q   <= CNT_LOAD;
                end
                DOING: begin
                    // count runs WIDTH..0, giving WIDTH+1 steps for the extended operands
                    acc_q   <= acc_d;
                    guard_q <= guard_d;
                    cnt_q   <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_q  <= FINISH;
                        result_q <= result_d;
`ifdef MUL_OVERFLOW_EN
                        ovf_q    <= ovf_d;
`endif
                    end
                end
                FINISH: begin
                    state_q <= FINISH;
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    assign result  = result_q;
    assign op_done = (state_q == FINISH);
    assign busy    = (state_q == START) || (state_q == DOING);
`ifdef MUL_OVERFLOW_EN
    assign result_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Self-checking bench for seq_booth_multiplier at WIDTH=8 and WIDTH=32.
// Vector table plus random operands against an arithmetic product model; hand sequences for abort/reset/hold.
// Honours MUL_OVERFLOW_EN when the design is built with it.
module tb_seq_booth_multiplier;

    logic clk;
    logic reset_n;

    logic        s8_start, s8_clear, s8_signed;
    logic [7:0]  a8, b8;
    logic [15:0] res8;
    logic        done8, busy8;

    logic        s32_start, s32_clear, s32_signed;
    logic [31:0] a32, b32;
    logic [63:0] res32;
    logic        done32, busy32;
`ifdef MUL_OVERFLOW_EN
    logic        ovf8, ovf32;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    seq_booth_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .op_start(s8_start), .op_clear(s8_clear),
        .op_signed(s8_signed), .multiplicand(a8), .multiplier(b8),
        .result(res8), .op_done(done8), .busy(busy8)
`ifdef MUL_OVERFLOW_EN
        , .result_ovf(ovf8)
`endif
    );

    seq_booth_multiplier #(.WIDTH(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .op_start(s32_start), .op_clear(s32_clear),
        .op_signed(s32_signed), .multiplicand(a32), .multiplier(b32),
        .result(res32), .op_done(done32), .busy(busy32)
`ifdef MUL_OVERFLOW_EN
        , .result_ovf(ovf32)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Mathematical product of the w-bit operands, interpreted per mode, modulo 2^64.
    function automatic logic [63:0] ref_full(input logic [31:0] a, input logic [31:0] b,
                                             input bit s, input int w);
        logic [63:0] x, y;
        x = 64'(a);
        y = 64'(b);
        if (s && a[w-1]) x = x | (~64'd0 << w);
        if (s && b[w-1]) y = y | (~64'd0 << w);
        return x * y;
    endfunction

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input bit s, input int w);
        logic [63:0] m;
        m = (2 * w >= 64) ? ~64'd0 : ((64'd1 << (2 * w)) - 64'd1);
        return ref_full(a, b, s, w) & m;
    endfunction

`ifdef MUL_OVERFLOW_EN
    function automatic bit ref_ovf(input logic [31:0] a, input logic [31:0] b,
                                   input bit s, input int w);
        logic [63:0] p;
        longint sp, lim;
        p = ref_full(a, b, s, w);
        if (s) begin
            sp  = longint'(p);
            lim = longint'(64'd1 << (w - 1));
            return (sp < -lim) || (sp >= lim);
        end
        return (p >> w) != 64'd0;
    endfunction
`endif

    // Launch one WIDTH=8 operation from CLEAR at a negedge; measure cycles from the start edge to op_done.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit s, input bit leave,
                        output logic [15:0] r, output bit ov, output int lat, output int bb);
        s8_start = 1'b1; a8 = a; b8 = b; s8_signed = s;
        @(negedge clk);
        s8_start = 1'b0; a8 = '0; b8 = '0; s8_signed = 1'b0;
        lat = 0;
        bb  = 0;
        while (!done8 && lat < 200) begin
            if (!busy8) bb++;
            @(negedge clk);
            lat++;
        end
        if (done8 && busy8) bb++;
        r  = res8;
        ov = 1'b0;
`ifdef MUL_OVERFLOW_EN
        ov = ovf8;
`endif
        if (!leave) begin
            s8_clear = 1'b1;
            @(negedge clk);
            s8_clear = 1'b0;
        end
    endtask

    task automatic run32(input logic [31:0] a, input logic [31:0] b, input bit s,
                         output logic [63:0] r, output bit ov, output int lat, output int bb);
        s32_start = 1'b1; a32 = a; b32 = b; s32_signed = s;
        @(negedge clk);
        s32_start = 1'b0; a32 = '0; b32 = '0; s32_signed = 1'b0;
        lat = 0;
        bb  = 0;
        while (!done32 && lat < 200) begin
            if (!busy32) bb++;
            @(negedge clk);
            lat++;
        end
        if (done32 && busy32) bb++;
        r  = res32;
        ov = 1'b0;
`ifdef MUL_OVERFLOW_EN
        ov = ovf32;
`endif
        s32_clear = 1'b1;
        @(negedge clk);
        s32_clear = 1'b0;
    endtask

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] res;
        logic        ovf;
    } vec_t;

    localparam int NV = 12;
    vec_t tv [NV];

    initial begin
        logic [15:0] r8;
        logic [63:0] r64, e64;
        logic [7:0]  ra, rb;
        logic [31:0] ra32, rb32;
        bit          ov, rs;
        int          lat, bb;

        tv[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1};
        tv[1]  = '{8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b0};
        tv[2]  = '{8'h80, 8'h80, 1'b1, 16'h4000, 1'b1};
        tv[3]  = '{8'h07, 8'h06, 1'b0, 16'h002A, 1'b0};
        tv[4]  = '{8'h0C, 8'h0C, 1'b0, 16'h0090, 1'b0};
        tv[5]  = '{8'h00, 8'hFF, 1'b1, 16'h0000, 1'b0};
        tv[6]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01, 1'b1};
        tv[7]  = '{8'hFF, 8'h01, 1'b1, 16'hFFFF, 1'b0};
        tv[8]  = '{8'h80, 8'h02, 1'b0, 16'h0100, 1'b1};
        tv[9]  = '{8'h0F, 8'h11, 1'b0, 16'h00FF, 1'b0};
        tv[10] = '{8'h80, 8'h01, 1'b1, 16'hFF80, 1'b0};
        tv[11] = '{8'h80, 8'h7F, 1'b1, 16'hC080, 1'b1};

        reset_n = 1'b0;
        s8_start = 0; s8_clear = 0; s8_signed = 0; a8 = '0; b8 = '0;
        s32_start = 0; s32_clear = 0; s32_signed = 0; a32 = '0; b32 = '0;
        repeat (2) @(negedge clk);
        check("reset_result8", 64'(res8), 64'd0);
        check("reset_done8", 64'(done8), 64'd0);
        check("reset_busy8", 64'(busy8), 64'd0);
        check("reset_result32", res32, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_busy8", 64'(busy8), 64'd0);

        // Table of known products
        for (int i = 0; i < NV; i++) begin
            run8(tv[i].a, tv[i].b, tv[i].s, 1'b0, r8, ov, lat, bb);
            check($sformatf("vec%0d_result", i), 64'(r8), 64'(tv[i].res));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd10);
            check($sformatf("vec%0d_busy_done", i), 64'(bb), 64'd0);
`ifdef MUL_OVERFLOW_EN
            check($sformatf("vec%0d_ovf", i), 64'(ov), 64'(tv[i].ovf));
`endif
        end

        // Random operands against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom_range(0, 1));
            run8(ra, rb, rs, 1'b0, r8, ov, lat, bb);
            e64 = ref_prod(32'(ra), 32'(rb), rs, 8);
            check($sformatf("rand%0d_result", i), 64'(r8), e64);
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'd10);
`ifdef MUL_OVERFLOW_EN
            check($sformatf("rand%0d_ovf", i), 64'(ov), 64'(ref_ovf(32'(ra), 32'(rb), rs, 8)));
`endif
        end

        // start and clear together in CLEAR: stay idle
        s8_start = 1'b1; s8_clear = 1'b1; a8 = 8'd9; b8 = 8'd9;
        @(negedge clk);
        check("start_clear_busy", 64'(busy8), 64'd0);
        check("start_clear_done", 64'(done8), 64'd0);
        s8_start = 1'b0; s8_clear = 1'b0;
        @(negedge clk);
        check("start_clear_busy_after", 64'(busy8), 64'd0);

        // op_start in FINISH is ignored
        run8(8'h0D, 8'h0B, 1'b0, 1'b1, r8, ov, lat, bb);
        check("hold_result", 64'(r8), 64'h008F);
        s8_start = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        @(negedge clk);
        s8_start = 1'b0; a8 = '0; b8 = '0;
        check("hold_result_after_start", 64'(res8), 64'h008F);
        check("hold_done_after_start", 64'(done8), 64'd1);
        @(negedge clk);
        check("hold_busy_later", 64'(busy8), 64'd0);
        s8_clear = 1'b1;
        @(negedge clk);
        s8_clear = 1'b0;
        check("hold_cleared_result", 64'(res8), 64'd0);

        // abort on the 4th DOING cycle, then restart
        s8_start = 1'b1; a8 = 8'd100; b8 = 8'd3;
        @(negedge clk);
        s8_start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_before", 64'(busy8), 64'd1);
        s8_clear = 1'b1;
        @(negedge clk);
        s8_clear = 1'b0;
        check("abort_done", 64'(done8), 64'd0);
        check("abort_result", 64'(res8), 64'd0);
        check("abort_busy", 64'(busy8), 64'd0);
        run8(8'd7, 8'd6, 1'b0, 1'b0, r8, ov, lat, bb);
        check("restart_result", 64'(r8), 64'h002A);
        check("restart_latency", 64'(lat), 64'd10);

        // asynchronous reset mid-operation
        s8_start = 1'b1; a8 = 8'd200; b8 = 8'd200;
        @(negedge clk);
        s8_start = 1'b0;
        repeat (5) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy8), 64'd0);
        check("arst_done", 64'(done8), 64'd0);
        check("arst_result", 64'(res8), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run8(8'd12, 8'd12, 1'b0, 1'b0, r8, ov, lat, bb);
        check("post_reset_result", 64'(r8), 64'h0090);
        check("post_reset_latency", 64'(lat), 64'd10);

        // WIDTH=32 corner and random cases
        run32(32'hFFFF_FFFF, 32'd2, 1'b1, r64, ov, lat, bb);
        check("w32_signed_result", r64, 64'hFFFF_FFFF_FFFF_FFFE);
        check("w32_signed_latency", 64'(lat), 64'd34);
        check("w32_signed_busy_done", 64'(bb), 64'd0);
`ifdef MUL_OVERFLOW_EN
        check("w32_signed_ovf", 64'(ov), 64'd0);
`endif
        run32(32'hFFFF_FFFF, 32'd2, 1'b0, r64, ov, lat, bb);
        check("w32_unsigned_result", r64, 64'h0000_0001_FFFF_FFFE);
        check("w32_unsigned_latency", 64'(lat), 64'd34);
`ifdef MUL_OVERFLOW_EN
        check("w32_unsigned_ovf", 64'(ov), 64'd1);
`endif
        for (int i = 0; i < 6; i++) begin
            ra32 = $urandom;
            rb32 = $urandom;
            rs   = 1'($urandom_range(0, 1));
            run32(ra32, rb32, rs, r64, ov, lat, bb);
            e64 = ref_prod(ra32, rb32, rs, 32);
            check($sformatf("w32_rand%0d_result", i), r64, e64);
`ifdef MUL_OVERFLOW_EN
            check($sformatf("w32_rand%0d_ovf", i), 64'(ov), 64'(ref_ovf(ra32, rb32, rs, 32)));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_booth_multiplier.md
# seq_booth_multiplier

Parametrised sequential multiplier for the ALU's multiply path: computes the full 2×WIDTH-bit product of two WIDTH-bit operands, signed or unsigned, selected per operation. One radix-2 Booth step is performed per clock under a four-state control FSM driven by the ALU's op_start/op_clear handshake. The result is held with op_done until the ALU clears it. The block replaces the fixed 32-bit controller plus external datapath with a single self-contained unit.

## Interface
- WIDTH, 32, operand width in bits (≥4); product is 2×WIDTH bits
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- op_start  in  1  start request, sampled only in CLEAR
- op_clear  in  1  clear/abort; highest priority in every state
- op_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with op_start
- multiplicand  in  WIDTH  operand A, sampled with op_start
- multiplier  in  WIDTH  operand B, sampled with op_start
- result  out  2×WIDTH  product; 0 outside FINISH
- op_done  out  1  1 iff state is FINISH
- busy  out  1  1 iff state is START or DOING
- result_ovf  out  1  present only with MUL_OVERFLOW_EN (see Configuration)

## Operation
- States (2-bit): CLEAR=00, FINISH=01, START=10, DOING=11.
- CLEAR: op_clear=1 → CLEAR; op_start=0 → CLEAR; else → START, capturing multiplicand, multiplier, op_signed on that edge.
- START: op_clear=1 → CLEAR; else → DOING; accumulator initialised (upper half 0, lower part = extended multiplier, Booth guard bit 0), count loaded with WIDTH.
- DOING: every edge performs one Booth step and decrements count; op_clear=1 → CLEAR (step discarded); count==0 → FINISH (final step performed); else DOING.
- FINISH: hold result; op_clear=1 → CLEAR; else FINISH. op_start ignored.
- Arithmetic: operands extended to WIDTH+1 bits (sign-extend if op_signed, else zero-extend); radix-2 Booth on the extended multiplier; WIDTH+1 steps total; result = low 2×WIDTH bits of the product, exact for both modes.
- Any transition into CLEAR zeroes operand registers, accumulator, count and result.
- op_start asserted in START/DOING/FINISH has no effect; the ALU must clear before re-starting.
- op_start and op_clear both 1 in CLEAR → remain in CLEAR.

## Timing
- Reset (reset_n=0, asynchronous): state CLEAR, result 0, op_done 0, busy 0, result_ovf 0, all internal registers 0.
- All outputs registered or decoded from registered state only; no combinational input-to-output path.
- Latency: op_start sampled at edge E0 → START after E0, DOING after E1, FINISH after E(WIDTH+2); op_done and valid result visible WIDTH+2 cycles after E0 (10 cycles at WIDTH=8, 34 at WIDTH=32).
- busy high from E0 through E(WIDTH+2) exclusive; op_done and busy never high together.
- op_clear sampled at edge Ek in any state: state CLEAR, op_done 0, result 0 after Ek.
- reset_n deasserted mid-operation: operation lost, block returns to CLEAR immediately.

## Configuration
- MUL_OVERFLOW_EN defined: result_ovf port exists; in FINISH it is 1 when the product does not fit in WIDTH bits — unsigned: result[2W-1:W] ≠ 0; signed: result[2W-1:W-1] not all equal. 0 in every other state; registered with result.
- Not defined: result_ovf port and its logic absent; all other behaviour identical.

## Structure
- Shared package mul_pkg: state encoding constants (CLEAR, FINISH, START, DOING), state type, count-width helper ($clog2(WIDTH+1)).
- One combinational sub-module booth_step: takes accumulator, guard bit and extended multiplicand, returns next accumulator after add/subtract/none and arithmetic right shift by one.
- Controller, operand registers, counter and result register live in the top module.

## Test plan
- WIDTH=8, unsigned 255×255 → result 0xFE01, op_done rises exactly 10 cycles after start edge; result_ovf=1 (macro on).
- WIDTH=8, signed −3×5 → result 0xFFF1, result_ovf=0; signed −128×−128 → 0x4000, result_ovf=1.
- WIDTH=8, op_clear asserted on the 4th DOING cycle → next cycle CLEAR, op_done 0, result 0; immediate restart 7×6 → 0x002A.
- op_start and op_clear both 1 in CLEAR → stays CLEAR, busy 0; op_start pulsed in FINISH → result and op_done unchanged.
- reset_n pulsed low mid-DOING → outputs 0 asynchronously (before next clock edge), then a normal 12×12 → 0x0090 completes.
- WIDTH=32, signed 0xFFFFFFFF×2 → 0xFFFFFFFF_FFFFFFFE, latency 34 cycles; unsigned same operands → 0x00000001_FFFFFFFE.
